pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 4, giving MDU multiply latency in cycles (legal 1..63).
REQ-002 The block SHALL have parameter DIV_CYCLES, default 32, giving MDU divide latency in cycles (legal 1..63).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have ports id_rs and id_rt, input, 5 bits each: source register numbers of the instruction in ID.
REQ-006 The block SHALL have ports id_rs_used and id_rt_used, input, 1 bit each: the ID instruction reads rs / rt.
REQ-007 The block SHALL have port exe_is_load, input, 1 bit: the EXE instruction is a load.
REQ-008 The block SHALL have port exe_rf_waddr, input, 5 bits: destination register of the EXE instruction.
REQ-009 The block SHALL have port id_branch_taken, input, 1 bit: ID resolved a taken branch or jump.
REQ-010 The block SHALL have port id_mdu_start, input, 1 bit: the ID instruction is mult/div.
REQ-011 The block SHALL have port id_mdu_div, input, 1 bit: 1 = divide, 0 = multiply; qualified by id_mdu_start.
REQ-012 The block SHALL have port id_mdu_read, input, 1 bit: the ID instruction reads the MDU result (mfhi/mflo).
REQ-013 The block SHALL have port if_pc_sel, output, 2 bits: 00 adder, 01 id_pc, 1x now_pc (hold).
REQ-014 The block SHALL have port if_id_hold, output, 1 bit: freeze the IF/ID register.
REQ-015 The block SHALL have port id_exe_flush, output, 1 bit: insert a bubble into ID/EXE.
REQ-016 The block SHALL have port mdu_start, output, 1 bit: one-cycle MDU launch pulse.
REQ-017 The block SHALL have port mdu_busy, output, 1 bit: the MDU is executing.
REQ-018 The block SHALL have port stall_cnt, output, 32 bits: stall-cycle counter (see Configuration).

Function
REQ-019 load_stall SHALL be 1 when exe_is_load=1, exe_rf_waddr!=0, and (id_rs_used and id_rs==exe_rf_waddr, or id_rt_used and id_rt==exe_rf_waddr).
REQ-020 mdu_stall SHALL be 1 when mdu_busy=1 and (id_mdu_start=1 or id_mdu_read=1).
REQ-021 stall SHALL be load_stall OR mdu_stall; when stall=1: if_pc_sel=2'b10, if_id_hold=1, id_exe_flush=1.
REQ-022 When stall=0 and id_branch_taken=1, if_pc_sel SHALL be 2'b01; otherwise it SHALL be 2'b00; stall takes priority over redirect, and a held branch SHALL be re-evaluated the next cycle.
REQ-023 if_pc_sel, if_id_hold, id_exe_flush and mdu_start SHALL be combinational from inputs and current state (zero latency).
REQ-024 The MDU sequencer SHALL have FSM states IDLE and BUSY, plus a 6-bit down-counter cnt.
REQ-025 In IDLE with id_mdu_start=1 and stall=0: mdu_start SHALL be 1 that cycle; next state BUSY; cnt loaded with DIV_CYCLES-1 if id_mdu_div, else MUL_CYCLES-1.
REQ-026 In BUSY with cnt!=0, cnt SHALL decrement; with cnt==0, next state SHALL be IDLE.
REQ-027 mdu_busy SHALL be 1 exactly while the state is BUSY, giving exactly LAT busy cycles after the accept cycle.
REQ-028 mdu_start SHALL be 0 in BUSY.
REQ-029 A start in ID while BUSY SHALL be held by mdu_stall and accepted in the first cycle the state is IDLE.
REQ-030 A start coincident with load_stall SHALL NOT be accepted.

Reset
REQ-031 While rst_n=0 at a clock edge: state SHALL become IDLE, cnt 0 and stall_cnt 0; therefore mdu_busy=0, and mdu_start=0 during reset.
REQ-032 Reset mid-BUSY SHALL abandon the operation with no completion pulse.

Configuration
REQ-033 With macro PIPE_STALL_CNT_EN defined, stall_cnt SHALL increment by 1 on every clock with stall=1, saturating at 32'hFFFF_FFFF.
REQ-034 Without PIPE_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter flops SHALL exist.

Structure
REQ-035 Shared package pipe_pkg SHALL hold the PC-select encodings (PC_SEL_ADDER=2'b00, PC_SEL_IDPC=2'b01, PC_SEL_HOLD=2'b10) and the MDU FSM state type.
REQ-036 The MDU FSM and counter SHALL be sub-module mdu_seq; hazard detection and the select logic SHALL stay in the top module.

Verification
REQ-037 Load-use stall: exe_is_load=1, exe_rf_waddr=5, id_rs=5, id_rs_used=1 -> one cycle of if_pc_sel=10, if_id_hold=1, id_exe_flush=1; same with exe_rf_waddr=0 -> no stall.
REQ-038 Multiply: accept mult at cycle t -> mdu_start=1 at t; mdu_busy=1 for t+1..t+4; mfhi presented at t+1 stalls 4 cycles and proceeds at t+5.
REQ-039 Back-to-back: div accepted, then mult in ID -> mult stalled 32 cycles, then accepted with a single mdu_start pulse.
REQ-040 Priority: id_branch_taken=1 with load_stall=1 -> if_pc_sel=10; next cycle, no hazard -> if_pc_sel=01.
REQ-041 Reset: rst_n=0 at busy cycle 10 of a divide -> next cycle mdu_busy=0, stall_cnt=0, if_pc_sel=00.
REQ-042 Counter: with PIPE_STALL_CNT_EN, 7 stall cycles -> stall_cnt=7; without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: PC-select
// encodings and the MDU sequencer state type.
package pipe_pkg;

  localparam logic [1:0] PC_SEL_ADDER = 2'b00;
  localparam logic [1:0] PC_SEL_IDPC  = 2'b01;
  localparam logic [1:0] PC_SEL_HOLD  = 2'b10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the hazard
// controller (slave).
interface pipe_hazard_ctrl_if;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_used;
  logic        id_rt_used;
  logic        exe_is_load;
  logic [4:0]  exe_rf_waddr;
  logic        id_branch_taken;
  logic        id_mdu_start;
  logic        id_mdu_div;
  logic        id_mdu_read;
  logic [1:0]  if_pc_sel;
  logic        if_id_hold;
  logic        id_exe_flush;
  logic        mdu_start;
  logic        mdu_busy;
  logic [31:0] stall_cnt;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, exe_is_load, exe_rf_waddr,
           id_branch_taken, id_mdu_start, id_mdu_div, id_mdu_read,
    input  if_pc_sel, if_id_hold, id_exe_flush, mdu_start, mdu_busy, stall_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, exe_is_load, exe_rf_waddr,
           id_branch_taken, id_mdu_start, id_mdu_div, id_mdu_read,
    output if_pc_sel, if_id_hold, id_exe_flush, mdu_start, mdu_busy, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_mdu_seq.sv
// MDU sequencer: accepts a mult/div launch when idle and not stalled, then
// reports busy for exactly the configured latency.
module mdu_seq
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_req,
  input  logic div,
  input  logic stall,
  output logic mdu_start,
  output logic mdu_busy
);

  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

  mdu_state_t state;
  logic [5:0] cnt;
  logic       accept;

  // Launch decision is combinational so the pulse appears in the accept cycle.
  assign accept    = (state == MDU_IDLE) && start_req && !stall;
  assign mdu_start = rst_n && accept;

  // Sequencer state, latency down-counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= MDU_IDLE;
      cnt      <= '0;
      mdu_busy <= 1'b0;
    end else begin
      case (state)
        MDU_IDLE: begin
          if (accept) begin
            state    <= MDU_BUSY;
            mdu_busy <= 1'b1;
            cnt      <= div ? DIV_LOAD : MUL_LOAD;
          end
        end
        MDU_BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 6'd1;
          end else begin
            state    <= MDU_IDLE;
            mdu_busy <= 1'b0;
          end
        end
        default: begin
          state    <= MDU_IDLE;
          mdu_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and MDU-busy stall detection, PC
// select / IF-ID hold / ID-EXE flush generation, and an optional stall-cycle
// counter enabled by macro PIPE_STALL_CNT_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipe_hazard_ctrl_if.slave      bus
);

  logic load_stall;
  logic mdu_stall;
  logic stall;

  // Hazard detection; register 0 is never a real dependency.
  always_comb begin
    load_stall = 1'b0;
    if (bus.exe_is_load && (bus.exe_rf_waddr != 5'd0)) begin
      load_stall = (bus.id_rs_used && (bus.id_rs == bus.exe_rf_waddr)) ||
                   (bus.id_rt_used && (bus.id_rt == bus.exe_rf_waddr));
    end
    mdu_stall = bus.mdu_busy && (bus.id_mdu_start || bus.id_mdu_read);
    stall     = load_stall || mdu_stall;
  end

  // Front-end control: stall wins over a branch redirect.
  always_comb begin
    bus.if_pc_sel    = PC_SEL_ADDER;
    bus.if_id_hold   = 1'b0;
    bus.id_exe_flush = 1'b0;
    if (stall) begin
      bus.if_pc_sel    = PC_SEL_HOLD;
      bus.if_id_hold   = 1'b1;
      bus.id_exe_flush = 1'b1;
    end else if (bus.id_branch_taken) begin
      bus.if_pc_sel = PC_SEL_IDPC;
    end
  end

  mdu_seq #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_req (bus.id_mdu_start),
    .div       (bus.id_mdu_div),
    .stall     (stall),
    .mdu_start (bus.mdu_start),
    .mdu_busy  (bus.mdu_busy)
  );

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference model state: remaining busy cycles and stall count.
  int      m_busy_left = 0;
  longint  m_stall_cnt = 0;

  pipe_hazard_ctrl_if hif ();

  pipe_hazard_ctrl #(
    .MUL_CYCLES (MUL_LAT),
    .DIV_CYCLES (DIV_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (hif.slave)
  );

  always #5 clk = ~clk;

  function automatic longint exp_cnt();
`ifdef PIPE_STALL_CNT_EN
    return m_stall_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic void model_comb(output logic st, output logic [1:0] sel,
                                     output logic start);
    logic ls;
    logic ms;
    ls = hif.exe_is_load && (hif.exe_rf_waddr != 0) &&
         ((hif.id_rs_used && hif.id_rs == hif.exe_rf_waddr) ||
          (hif.id_rt_used && hif.id_rt == hif.exe_rf_waddr));
    ms = (m_busy_left > 0) && (hif.id_mdu_start || hif.id_mdu_read);
    st = ls || ms;
    sel = st ? 2'b10 : (hif.id_branch_taken ? 2'b01 : 2'b00);
    start = rst_n && (m_busy_left == 0) && hif.id_mdu_start && !st;
  endfunction

  task automatic tick();
    logic st;
    logic start;
    logic [1:0] sel;
    logic r;
    logic dv;
    model_comb(st, sel, start);
    r  = rst_n;
    dv = hif.id_mdu_div;
    @(posedge clk);
    if (!r) begin
      m_busy_left = 0;
      m_stall_cnt = 0;
    end else begin
      if (start) m_busy_left = dv ? DIV_LAT : MUL_LAT;
      else if (m_busy_left > 0) m_busy_left--;
      if (st && m_stall_cnt != 64'hFFFF_FFFF) m_stall_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    hif.id_rs = '0; hif.id_rt = '0; hif.id_rs_used = 0; hif.id_rt_used = 0;
    hif.exe_is_load = 0; hif.exe_rf_waddr = '0; hif.id_branch_taken = 0;
    hif.id_mdu_start = 0; hif.id_mdu_div = 0; hif.id_mdu_read = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    hif.id_mdu_start = 1;
    tick();
    tick();
    #1;
    total++; if (hif.mdu_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", hif.mdu_busy); end
    total++; if (hif.mdu_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", hif.mdu_start); end
    total++; if (hif.stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", hif.stall_cnt); end
    hif.id_mdu_start = 0;
    #1;
    total++; if (hif.if_pc_sel !== 2'b00) begin bad++; $display("FAIL reset_pcsel got=%b exp=00", hif.if_pc_sel); end
    rst_n = 1;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    hif.exe_is_load = 1; hif.exe_rf_waddr = 5; hif.id_rs = 5; hif.id_rs_used = 1;
    #1;
    total++; if ({hif.if_pc_sel, hif.if_id_hold, hif.id_exe_flush} !== 4'b1011)
      begin bad++; $display("FAIL load_use got=%b exp=1011", {hif.if_pc_sel, hif.if_id_hold, hif.id_exe_flush}); end
    tick();
    hif.exe_is_load = 0;
    #1;
    total++; if ({hif.if_pc_sel, hif.if_id_hold, hif.id_exe_flush} !== 4'b0000)
      begin bad++; $display("FAIL load_use_release got=%b exp=0000", {hif.if_pc_sel, hif.if_id_hold, hif.id_exe_flush}); end
    hif.exe_is_load = 1; hif.exe_rf_waddr = 0; hif.id_rs = 0;
    #1;
    total++; if (hif.if_id_hold !== 1'b0) begin bad++; $display("FAIL load_r0 got=%b exp=0", hif.if_id_hold); end
    hif.exe_rf_waddr = 9; hif.id_rs = 1; hif.id_rt = 9; hif.id_rt_used = 1;
    #1;
    total++; if (hif.id_exe_flush !== 1'b1) begin bad++; $display("FAIL load_rt got=%b exp=1", hif.id_exe_flush); end
    hif.id_rt_used = 0;
    #1;
    total++; if (hif.id_exe_flush !== 1'b0) begin bad++; $display("FAIL load_rt_unused got=%b exp=0", hif.id_exe_flush); end
    tick();
    clear_inputs();
  endtask

  task automatic test_mult();
    do_reset();
    hif.id_mdu_start = 1; hif.id_mdu_div = 0;
    #1;
    total++; if (hif.mdu_start !== 1'b1) begin bad++; $display("FAIL mult_start got=%b exp=1", hif.mdu_start); end
    tick();
    hif.id_mdu_start = 0; hif.id_mdu_read = 1;
    for (int i = 1; i <= MUL_LAT; i++) begin
      #1;
      total++; if (hif.mdu_busy !== 1'b1) begin bad++; $display("FAIL mult_busy_%0d got=%b exp=1", i, hif.mdu_busy); end
      total++; if (hif.if_pc_sel !== 2'b10) begin bad++; $display("FAIL mfhi_stall_%0d got=%b exp=10", i, hif.if_pc_sel); end
      total++; if (hif.mdu_start !== 1'b0) begin bad++; $display("FAIL mult_nostart_%0d got=%b exp=0", i, hif.mdu_start); end
      tick();
    end
    #1;
    total++; if ({hif.mdu_busy, hif.if_pc_sel} !== 3'b000) begin bad++; $display("FAIL mfhi_proceed got=%b exp=000", {hif.mdu_busy, hif.if_pc_sel}); end
    tick();
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    int stalls = 0;
    int pulses = 0;
    bit accepted = 0;
    do_reset();
    hif.id_mdu_start = 1; hif.id_mdu_div = 1;
    #1;
    total++; if (hif.mdu_start !== 1'b1) begin bad++; $display("FAIL div_start got=%b exp=1", hif.mdu_start); end
    tick();
    hif.id_mdu_div = 0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      #1;
      if (hif.mdu_start === 1'b1) begin accepted = 1; pulses++; end
      else if (hif.if_pc_sel === 2'b10) stalls++;
      tick();
    end
    total++; if (!accepted) begin bad++; $display("FAIL b2b_accept got=timeout exp=accepted"); end
    total++; if (stalls != DIV_LAT) begin bad++; $display("FAIL b2b_stalls got=%0d exp=%0d", stalls, DIV_LAT); end
    hif.id_mdu_start = 0;
    for (int i = 0; i < MUL_LAT; i++) begin
      #1;
      if (hif.mdu_start === 1'b1) pulses++;
      tick();
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL b2b_pulses got=%0d exp=1", pulses); end
    #1;
    total++; if (hif.mdu_busy !== 1'b0) begin bad++; $display("FAIL b2b_done got=%b exp=0", hif.mdu_busy); end
    clear_inputs();
  endtask

  task automatic test_priority();
    do_reset();
    hif.id_branch_taken = 1;
    hif.exe_is_load = 1; hif.exe_rf_waddr = 7; hif.id_rt = 7; hif.id_rt_used = 1;
    #1;
    total++; if (hif.if_pc_sel !== 2'b10) begin bad++; $display("FAIL prio_stall got=%b exp=10", hif.if_pc_sel); end
    tick();
    hif.exe_is_load = 0;
    #1;
    total++; if (hif.if_pc_sel !== 2'b01) begin bad++; $display("FAIL prio_redirect got=%b exp=01", hif.if_pc_sel); end
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    hif.id_mdu_start = 1; hif.id_mdu_div = 1;
    tick();
    clear_inputs();
    hif.exe_is_load = 1; hif.exe_rf_waddr = 3; hif.id_rs = 3; hif.id_rs_used = 1;
    for (int i = 1; i < 10; i++) tick();
    clear_inputs();
    rst_n = 0;
    tick();
    #1;
    total++; if (hif.mdu_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", hif.mdu_busy); end
    total++; if (hif.stall_cnt !== 32'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=0", hif.stall_cnt); end
    total++; if (hif.if_pc_sel !== 2'b00) begin bad++; $display("FAIL rstmid_pcsel got=%b exp=00", hif.if_pc_sel); end
    rst_n = 1;
    for (int i = 0; i < DIV_LAT + 2; i++) begin
      #1;
      total++; if ({hif.mdu_busy, hif.mdu_start} !== 2'b00) begin bad++; $display("FAIL rstmid_abandon got=%b exp=00", {hif.mdu_busy, hif.mdu_start}); end
      tick();
    end
  endtask

  task automatic test_stall_counter();
    longint exp;
    do_reset();
    hif.exe_is_load = 1; hif.exe_rf_waddr = 12; hif.id_rs = 12; hif.id_rs_used = 1;
    for (int i = 0; i < 7; i++) tick();
    clear_inputs();
    hif.id_branch_taken = 1;
    tick();
    #1;
`ifdef PIPE_STALL_CNT_EN
    exp = 7;
`else
    exp = 0;
`endif
    total++; if (hif.stall_cnt !== 32'(exp)) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", hif.stall_cnt, exp); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic st;
    logic start;
    logic [1:0] sel;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst_n                = ($urandom_range(0, 99) != 0);
      hif.id_rs            = 5'($urandom_range(0, 3));
      hif.id_rt            = 5'($urandom_range(0, 3));
      hif.id_rs_used       = 1'($urandom);
      hif.id_rt_used       = 1'($urandom);
      hif.exe_is_load      = ($urandom_range(0, 2) == 0);
      hif.exe_rf_waddr     = 5'($urandom_range(0, 3));
      hif.id_branch_taken  = ($urandom_range(0, 3) == 0);
      hif.id_mdu_start     = ($urandom_range(0, 5) == 0);
      hif.id_mdu_div       = ($urandom_range(0, 3) == 0);
      hif.id_mdu_read      = ($urandom_range(0, 3) == 0);
      #1;
      model_comb(st, sel, start);
      total++; if (hif.if_pc_sel !== sel) begin bad++; $display("FAIL rnd_pcsel cyc=%0d got=%b exp=%b", i, hif.if_pc_sel, sel); end
      total++; if (hif.if_id_hold !== st) begin bad++; $display("FAIL rnd_hold cyc=%0d got=%b exp=%b", i, hif.if_id_hold, st); end
      total++; if (hif.id_exe_flush !== st) begin bad++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", i, hif.id_exe_flush, st); end
      total++; if (hif.mdu_start !== start) begin bad++; $display("FAIL rnd_start cyc=%0d got=%b exp=%b", i, hif.mdu_start, start); end
      total++; if (hif.mdu_busy !== (m_busy_left > 0)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, hif.mdu_busy, (m_busy_left > 0)); end
      total++; if (hif.stall_cnt !== 32'(exp_cnt())) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, hif.stall_cnt, exp_cnt()); end
      tick();
    end
    rst_n = 1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_mult();
    test_back_to_back();
    test_priority();
    test_reset_mid_busy();
    test_stall_counter();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
